// File: rtl/mem_arb_pkg.sv
// Shared encodings for the IFU/LSU memory-port arbiter: FSM states and owner IDs.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_WAIT = 2'd2,
        ARB_RESP = 2'd3
    } arb_state_e;

    typedef enum logic {
        ARB_OWN_IFU = 1'b0,
        ARB_OWN_LSU = 1'b1
    } arb_owner_e;

    // Minimum width of the response-timeout counter.
    localparam int unsigned ARB_CNT_MIN_W = 8;

    // True while a transaction is outstanding on the memory side.
    function automatic logic arb_busy(input arb_state_e s);
        return (s == ARB_REQ) || (s == ARB_WAIT);
    endfunction

endpackage

// File: rtl/mem_arb_rr_arb2.sv
// Two-way round-robin grant; ties go to the master not granted last.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_ifu,
    input  logic       req_lsu,
    input  logic       en,
    output logic       gnt_ifu_c,
    output logic       gnt_lsu_c,
    output arb_owner_e owner_c
);

    arb_owner_e last_q;

    // Pick the winner from the current requests and the last-grant flag.
    always_comb begin
        owner_c = ARB_OWN_IFU;
        if (req_ifu && req_lsu) begin
            owner_c = (last_q == ARB_OWN_IFU) ? ARB_OWN_LSU : ARB_OWN_IFU;
        end else if (req_lsu) begin
            owner_c = ARB_OWN_LSU;
        end
        gnt_ifu_c = req_ifu && (owner_c == ARB_OWN_IFU);
        gnt_lsu_c = req_lsu && (owner_c == ARB_OWN_LSU);
    end

    // Remember who won whenever a grant is actually taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= ARB_OWN_IFU;
        end else if (en && (req_ifu || req_lsu)) begin
            last_q <= owner_c;
        end
    end

endmodule

// File: rtl/mem_arb.sv
// Shares one memory port between IFU (fetch) and LSU (load/store), one
// transaction at a time. Optional response timeout with error pulse is
// enabled by defining ARB_TIMEOUT_EN.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned MW      = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_ifu_valid,
    output logic          o_ifu_ready,
    input  logic [AW-1:0] i_ifu_addr,
    output logic          o_ifu_rvalid,
    output logic [DW-1:0] o_ifu_rdata,
    input  logic          i_lsu_valid,
    output logic          o_lsu_ready,
    input  logic [AW-1:0] i_lsu_addr,
    input  logic          i_lsu_wen,
    input  logic [DW-1:0] i_lsu_wdata,
    input  logic [MW-1:0] i_lsu_wmask,
    output logic          o_lsu_rvalid,
    output logic [DW-1:0] o_lsu_rdata,
    output logic          o_mem_valid,
    input  logic          i_mem_ready,
    output logic [AW-1:0] o_mem_addr,
    output logic          o_mem_wen,
    output logic [DW-1:0] o_mem_wdata,
    output logic [MW-1:0] o_mem_wmask,
    input  logic          i_mem_rvalid,
    input  logic [DW-1:0] i_mem_rdata
`ifdef ARB_TIMEOUT_EN
    ,
    output logic          o_err
`endif
);

    arb_state_e    state_q, state_d;
    arb_owner_e    owner_q;
    arb_owner_e    win_c;
    logic          gnt_ifu_c, gnt_lsu_c;
    logic          accept_c;
    logic          resp_load_c;
    logic          timeout_c;
    logic [DW-1:0] resp_data_c;

    logic          mem_valid_q;
    logic [AW-1:0] addr_q;
    logic          wen_q;
    logic [DW-1:0] wdata_q;
    logic [MW-1:0] wmask_q;
    logic          ifu_rvalid_q, lsu_rvalid_q;
    logic [DW-1:0] ifu_rdata_q, lsu_rdata_q;

    rr_arb2 u_rr (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .req_ifu   (i_ifu_valid),
        .req_lsu   (i_lsu_valid),
        .en        (accept_c),
        .gnt_ifu_c (gnt_ifu_c),
        .gnt_lsu_c (gnt_lsu_c),
        .owner_c   (win_c)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CW = ($clog2(TIMEOUT + 1) > ARB_CNT_MIN_W) ?
                                 $clog2(TIMEOUT + 1) : ARB_CNT_MIN_W;
    logic [CW-1:0] cnt_q;
    logic          err_q;

    // Fires on the last allowed REQ/WAIT cycle unless the response lands now.
    always_comb begin
        timeout_c = arb_busy(state_q) && (cnt_q == CW'(TIMEOUT - 1)) &&
                    !((state_q == ARB_WAIT) && i_mem_rvalid);
    end

    // Cycle counter: cleared when a request is accepted, runs in REQ/WAIT.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else if (accept_c) begin
            cnt_q <= '0;
        end else if (arb_busy(state_q)) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // Error pulse accompanies a timed-out response.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= timeout_c;
        end
    end

    assign o_err = err_q;
`else
    assign timeout_c = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, accept and response-capture decode.
    always_comb begin
        state_d     = state_q;
        accept_c    = 1'b0;
        resp_load_c = 1'b0;
        resp_data_c = '0;
        o_ifu_ready = 1'b0;
        o_lsu_ready = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                o_ifu_ready = gnt_ifu_c;
                o_lsu_ready = gnt_lsu_c;
                if (i_ifu_valid || i_lsu_valid) begin
                    accept_c = 1'b1;
                    state_d  = ARB_REQ;
                end
            end
            ARB_REQ: begin
                if (timeout_c) begin
                    resp_load_c = 1'b1;
                    state_d     = ARB_RESP;
                end else if (i_mem_ready) begin
                    state_d = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (timeout_c) begin
                    resp_load_c = 1'b1;
                    state_d     = ARB_RESP;
                end else if (i_mem_rvalid) begin
                    resp_load_c = 1'b1;
                    resp_data_c = wen_q ? '0 : i_mem_rdata;
                    state_d     = ARB_RESP;
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Latch the winning master's payload on accept; IFU is always a plain read.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            owner_q <= ARB_OWN_IFU;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else if (accept_c) begin
            owner_q <= win_c;
            if (win_c == ARB_OWN_LSU) begin
                addr_q  <= i_lsu_addr;
                wen_q   <= i_lsu_wen;
                wdata_q <= i_lsu_wdata;
                wmask_q <= i_lsu_wen ? i_lsu_wmask : '0;
            end else begin
                addr_q  <= i_ifu_addr;
                wen_q   <= 1'b0;
                wdata_q <= '0;
                wmask_q <= '0;
            end
        end
    end

    // Memory request valid mirrors the REQ state, registered.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mem_valid_q <= 1'b0;
        end else begin
            mem_valid_q <= (state_d == ARB_REQ);
        end
    end

    // One-cycle response pulse to the owner only.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ifu_rvalid_q <= 1'b0;
            lsu_rvalid_q <= 1'b0;
        end else begin
            ifu_rvalid_q <= resp_load_c && (owner_q == ARB_OWN_IFU);
            lsu_rvalid_q <= resp_load_c && (owner_q == ARB_OWN_LSU);
        end
    end

    // Per-master read data, held between response pulses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
        end else if (resp_load_c) begin
            if (owner_q == ARB_OWN_IFU) begin
                ifu_rdata_q <= resp_data_c;
            end else begin
                lsu_rdata_q <= resp_data_c;
            end
        end
    end

    assign o_mem_valid  = mem_valid_q;
    assign o_mem_addr   = addr_q;
    assign o_mem_wen    = wen_q;
    assign o_mem_wdata  = wdata_q;
    assign o_mem_wmask  = wmask_q;
    assign o_ifu_rvalid = ifu_rvalid_q;
    assign o_ifu_rdata  = ifu_rdata_q;
    assign o_lsu_rvalid = lsu_rvalid_q;
    assign o_lsu_rdata  = lsu_rdata_q;

endmodule

// File: tb/tb_mem_arb.sv
// Directed self-checking bench for mem_arb (timeout case only with ARB_TIMEOUT_EN).
module tb_mem_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ifu_valid = 1'b0;
    logic        ifu_ready;
    logic [31:0] ifu_addr = '0;
    logic        ifu_rvalid;
    logic [31:0] ifu_rdata;
    logic        lsu_valid = 1'b0;
    logic        lsu_ready;
    logic [31:0] lsu_addr = '0;
    logic        lsu_wen = 1'b0;
    logic [31:0] lsu_wdata = '0;
    logic [7:0]  lsu_wmask = '0;
    logic        lsu_rvalid;
    logic [31:0] lsu_rdata;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
`ifdef ARB_TIMEOUT_EN
    logic        err;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arb #(.AW(32), .DW(32), .MW(8), .TIMEOUT(16)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_ifu_valid  (ifu_valid),
        .o_ifu_ready  (ifu_ready),
        .i_ifu_addr   (ifu_addr),
        .o_ifu_rvalid (ifu_rvalid),
        .o_ifu_rdata  (ifu_rdata),
        .i_lsu_valid  (lsu_valid),
        .o_lsu_ready  (lsu_ready),
        .i_lsu_addr   (lsu_addr),
        .i_lsu_wen    (lsu_wen),
        .i_lsu_wdata  (lsu_wdata),
        .i_lsu_wmask  (lsu_wmask),
        .o_lsu_rvalid (lsu_rvalid),
        .o_lsu_rdata  (lsu_rdata),
        .o_mem_valid  (mem_valid),
        .i_mem_ready  (mem_ready),
        .o_mem_addr   (mem_addr),
        .o_mem_wen    (mem_wen),
        .o_mem_wdata  (mem_wdata),
        .o_mem_wmask  (mem_wmask),
        .i_mem_rvalid (mem_rvalid),
        .i_mem_rdata  (mem_rdata)
`ifdef ARB_TIMEOUT_EN
        ,
        .o_err        (err)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".ifu_ready"}, 64'(ifu_ready), 64'd0);
        chk({tag, ".lsu_ready"}, 64'(lsu_ready), 64'd0);
        chk({tag, ".ifu_rvalid"}, 64'(ifu_rvalid), 64'd0);
        chk({tag, ".lsu_rvalid"}, 64'(lsu_rvalid), 64'd0);
        chk({tag, ".ifu_rdata"}, 64'(ifu_rdata), 64'd0);
        chk({tag, ".lsu_rdata"}, 64'(lsu_rdata), 64'd0);
        chk({tag, ".mem_valid"}, 64'(mem_valid), 64'd0);
        chk({tag, ".mem_addr"}, 64'(mem_addr), 64'd0);
        chk({tag, ".mem_wen"}, 64'(mem_wen), 64'd0);
        chk({tag, ".mem_wdata"}, 64'(mem_wdata), 64'd0);
        chk({tag, ".mem_wmask"}, 64'(mem_wmask), 64'd0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Accept cycle already driven by caller; runs a minimum-latency transaction.
    task automatic txn(input string tag, input bit exp_lsu, input logic [31:0] exp_addr,
                       input bit exp_wen, input logic [31:0] exp_wdata,
                       input logic [7:0] exp_wmask, input logic [31:0] mrd,
                       input logic [31:0] exp_rd, input bit keep);
        @(negedge clk);
        chk({tag, ".ifu_ready"}, 64'(ifu_ready), 64'(!exp_lsu));
        chk({tag, ".lsu_ready"}, 64'(lsu_ready), 64'(exp_lsu));
        next_cycle();
        if (!keep) begin
            ifu_valid = 1'b0;
            lsu_valid = 1'b0;
        end
        mem_ready = 1'b1;
        @(negedge clk);
        chk({tag, ".req_valid"}, 64'(mem_valid), 64'd1);
        chk({tag, ".req_addr"}, 64'(mem_addr), 64'(exp_addr));
        chk({tag, ".req_wen"}, 64'(mem_wen), 64'(exp_wen));
        chk({tag, ".req_wdata"}, 64'(mem_wdata), 64'(exp_wdata));
        chk({tag, ".req_wmask"}, 64'(mem_wmask), 64'(exp_wmask));
        chk({tag, ".req_readies"}, 64'({ifu_ready, lsu_ready}), 64'd0);
        next_cycle();
        mem_ready  = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = mrd;
        @(negedge clk);
        chk({tag, ".wait_valid"}, 64'(mem_valid), 64'd0);
        next_cycle();
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        @(negedge clk);
        chk({tag, ".ifu_rvalid"}, 64'(ifu_rvalid), 64'(!exp_lsu));
        chk({tag, ".lsu_rvalid"}, 64'(lsu_rvalid), 64'(exp_lsu));
        chk({tag, ".rdata"}, 64'(exp_lsu ? lsu_rdata : ifu_rdata), 64'(exp_rd));
        chk({tag, ".resp_readies"}, 64'({ifu_ready, lsu_ready}), 64'd0);
        next_cycle();
    endtask

    initial begin
        // Reset state.
        #2;
        chk_all_zero("reset");
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // IFU-only fetch.
        ifu_valid = 1'b1;
        ifu_addr  = 32'h8000_0000;
        txn("ifu_fetch", 1'b0, 32'h8000_0000, 1'b0, 32'h0, 8'h00,
            32'h0000_0413, 32'h0000_0413, 1'b0);
        @(negedge clk);
        chk("ifu_fetch.pulse_end", 64'(ifu_rvalid), 64'd0);
        chk("ifu_fetch.rdata_hold", 64'(ifu_rdata), 64'h0000_0413);
        next_cycle();

        // LSU store: response data forced to zero.
        lsu_valid = 1'b1;
        lsu_addr  = 32'h8000_1000;
        lsu_wen   = 1'b1;
        lsu_wdata = 32'hDEAD_BEEF;
        lsu_wmask = 8'h0F;
        txn("lsu_store", 1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 8'h0F,
            32'h1234_5678, 32'h0, 1'b0);

        // Memory stall in REQ; last grant was LSU so IFU wins the tie.
        ifu_valid = 1'b1;
        ifu_addr  = 32'h8000_0040;
        lsu_valid = 1'b1;
        lsu_addr  = 32'h8000_2000;
        lsu_wen   = 1'b0;
        lsu_wdata = 32'h0;
        lsu_wmask = 8'h00;
        @(negedge clk);
        chk("stall.accept_ifu", 64'({ifu_ready, lsu_ready}), 64'b10);
        next_cycle();
        ifu_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall.mem_valid", 64'(mem_valid), 64'd1);
            chk("stall.mem_addr", 64'(mem_addr), 64'h8000_0040);
            chk("stall.lsu_ready", 64'(lsu_ready), 64'd0);
            next_cycle();
        end
        mem_ready = 1'b1;
        next_cycle();
        mem_ready  = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_0001;
        next_cycle();
        mem_rvalid = 1'b0;
        @(negedge clk);
        chk("stall.resp", 64'({ifu_rvalid, lsu_rvalid, lsu_ready}), 64'b100);
        chk("stall.rdata", 64'(ifu_rdata), 64'hCAFE_0001);
        next_cycle();

        // Waiting LSU load is accepted now, then reset hits in WAIT.
        @(negedge clk);
        chk("rst_wait.accept_lsu", 64'({ifu_ready, lsu_ready}), 64'b01);
        next_cycle();
        lsu_valid = 1'b0;
        mem_ready = 1'b1;
        next_cycle();
        mem_ready = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        chk_all_zero("rst_wait.in_reset");
        next_cycle();
        rst_n      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hAAAA_AAAA;
        next_cycle();
        mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_all_zero("rst_wait.after");
            next_cycle();
        end

        // Both masters valid from reset: LSU, IFU, LSU, IFU.
        ifu_valid = 1'b1;
        ifu_addr  = 32'h0000_0100;
        lsu_valid = 1'b1;
        lsu_addr  = 32'h0000_0200;
        txn("rr0_lsu", 1'b1, 32'h0000_0200, 1'b0, 32'h0, 8'h00, 32'h11, 32'h11, 1'b1);
        txn("rr1_ifu", 1'b0, 32'h0000_0100, 1'b0, 32'h0, 8'h00, 32'h22, 32'h22, 1'b1);
        txn("rr2_lsu", 1'b1, 32'h0000_0200, 1'b0, 32'h0, 8'h00, 32'h33, 32'h33, 1'b1);
        txn("rr3_ifu", 1'b0, 32'h0000_0100, 1'b0, 32'h0, 8'h00, 32'h44, 32'h44, 1'b0);
        @(negedge clk);
        chk("rr.lsu_rdata_hold", 64'(lsu_rdata), 64'h33);

`ifdef ARB_TIMEOUT_EN
        // Memory never answers: response after 16 cycles in REQ/WAIT.
        next_cycle();
        ifu_valid = 1'b1;
        ifu_addr  = 32'h8000_0080;
        @(negedge clk);
        chk("tmo.accept", 64'(ifu_ready), 64'd1);
        next_cycle();
        ifu_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("tmo.busy", 64'({mem_valid, ifu_rvalid, err}), 64'b100);
            next_cycle();
        end
        @(negedge clk);
        chk("tmo.resp", 64'({ifu_rvalid, lsu_rvalid, err}), 64'b101);
        chk("tmo.rdata", 64'(ifu_rdata), 64'd0);
        next_cycle();
        @(negedge clk);
        chk("tmo.done", 64'({ifu_rvalid, err, mem_valid}), 64'b000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
- Two-master, one-slave arbiter that shares the single data/instruction memory port between the IFU (fetch, read-only) and the LSU (load/store).
- Sits between the IFU/LSU and the memory model or bus bridge.
- Sequences one outstanding transaction at a time through a four-state FSM.
- Routes the response back to the master that issued it.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MW, 8, write-mask width (byte enables; bit i set = write byte i).
- TIMEOUT, 255, cycles to wait for a memory response; used only with ARB_TIMEOUT_EN.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_ifu_valid  in  1  IFU fetch request.
- o_ifu_ready  out  1  IFU request accepted this cycle.
- i_ifu_addr  in  AW  fetch address.
- o_ifu_rvalid  out  1  one-cycle fetch response pulse.
- o_ifu_rdata  out  DW  fetched instruction.
- i_lsu_valid  in  1  LSU request.
- o_lsu_ready  out  1  LSU request accepted this cycle.
- i_lsu_addr  in  AW  LSU address.
- i_lsu_wen  in  1  1 = store, 0 = load.
- i_lsu_wdata  in  DW  store data.
- i_lsu_wmask  in  MW  store byte mask.
- o_lsu_rvalid  out  1  one-cycle LSU response pulse (load data or store ack).
- o_lsu_rdata  out  DW  load data; 0 for stores.
- o_mem_valid  out  1  request to memory.
- i_mem_ready  in  1  memory accepted the request.
- o_mem_addr  out  AW  memory address.
- o_mem_wen  out  1  write enable.
- o_mem_wdata  out  DW  write data.
- o_mem_wmask  out  MW  write mask; 0 when o_mem_wen=0.
- i_mem_rvalid  in  1  memory response (read data or write ack).
- i_mem_rdata  in  DW  memory read data.
- o_err  out  1  timeout pulse; exists only with ARB_TIMEOUT_EN.

Behaviour:
- Reset (async, i_rst_n=0):
  - State goes to IDLE and the last-grant flag goes to IFU.
  - All outputs are 0, including all latched address/data registers.
- IDLE:
  - Arbitration is combinational on i_ifu_valid and i_lsu_valid.
  - If only one master is valid, it wins.
  - If both are valid, the winner is the master not granted last (round-robin). After reset the LSU wins the first tie.
  - The winner's o_*_ready is asserted in the same cycle. The loser's ready stays 0, and it must hold valid and payload stable until accepted.
  - On accept: latch addr, wen, wdata and wmask (IFU: wen=0, wmask=0), record the owner, update the last-grant flag, then go to REQ.
  - The ready outputs are 0 in every state except IDLE.
- REQ:
  - o_mem_valid=1 with the latched payload.
  - On i_mem_ready=1, go to WAIT; o_mem_valid drops the next cycle.
- WAIT:
  - Hold until i_mem_rvalid=1.
  - Latch i_mem_rdata, or 0 if the transaction was a write, then go to RESP.
  - i_mem_rvalid seen in REQ, or in the same cycle as i_mem_ready, is ignored; the earliest legal response is the cycle after acceptance.
- RESP:
  - The owner's o_*_rvalid=1 for exactly one cycle with the latched rdata; the other master's rvalid stays 0.
  - The next state is IDLE. There is no response backpressure: masters must sink the pulse.
- Latency:
  - Accept at cycle N, o_mem_valid at N+1.
  - With i_mem_ready=1 at N+1 and i_mem_rvalid=1 at N+2, the response pulse is at N+3. The minimum is 4 cycles per transaction, back-to-back.
- rdata outputs hold their last value between pulses.
- i_mem_rvalid in IDLE or RESP is dropped.
- Reset mid-transaction aborts it with no response; memory-side completion after reset is ignored.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit-min counter (width $clog2(TIMEOUT+1)) clears on entry to REQ and increments in REQ and WAIT.
  - On reaching TIMEOUT without completion, go to RESP with rdata=0 and o_err=1 for that one RESP cycle.
- Undefined:
  - No counter and no o_err port; REQ and WAIT wait indefinitely.

Decomposition:
- Shared defines header:
  - State encoding (ARB_IDLE=2'd0, ARB_REQ=2'd1, ARB_WAIT=2'd2, ARB_RESP=2'd3).
  - Owner encoding (ARB_OWN_IFU=1'b0, ARB_OWN_LSU=1'b1).
- Sub-module:
  - Natural sub-module: rr_arb2, a 2-way round-robin grant with a last-grant register.
  - Payload latches use the existing stdreg.

Test Plan:
- IFU only, addr 0x80000000, memory ready at N+1, rvalid at N+2 with rdata 0x00000413 -> o_ifu_ready at N; o_ifu_rvalid=1 and o_ifu_rdata=0x00000413 at N+3; o_lsu_rvalid stays 0.
- LSU store, addr 0x80001000, wdata 0xDEADBEEF, wmask 0x0F -> o_mem_wen=1, o_mem_wmask=0x0F during REQ; o_lsu_rvalid pulse with o_lsu_rdata=0.
- Both valid continuously for 4 transactions from reset -> grant order LSU, IFU, LSU, IFU; each response goes only to its owner.
- i_mem_ready held low 5 cycles in REQ -> o_mem_valid stays 1 with a stable payload; no ready to either master until RESP completes.
- Reset asserted in WAIT, then i_mem_rvalid=1 after release -> no rvalid to either master; all outputs 0 and state IDLE.
- With ARB_TIMEOUT_EN and TIMEOUT=16, memory never responds -> after 16 cycles in REQ/WAIT, the owner's rvalid=1 with rdata=0 and o_err=1 for one cycle, then IDLE.
